// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file address definitions
package regfile_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    localparam reg_addr_t REG_ZERO = reg_addr_t'(0);
    localparam reg_addr_t REG_RA   = reg_addr_t'(31);
endpackage

// File: rtl/regfile_if.sv
// regfile_if: read/write/debug port bundle of the register file
interface regfile_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    reg_addr_t        ra1, ra2, wa, dbg_a;
    logic             we;
    logic [WIDTH-1:0] wd, rd1, rd2, dbg_d;
    modport master (output ra1, ra2, we, wa, wd, dbg_a, input rd1, rd2, dbg_d);
    modport slave  (input ra1, ra2, we, wa, wd, dbg_a, output rd1, rd2, dbg_d);
endinterface

// File: rtl/regfile_dec.sv
// decoder5to32: one-hot select of a 5-bit register address (unknown address yields no valid bit)
module decoder5to32
    import regfile_pkg::*;
(
    input  reg_addr_t           a,
    output logic [NUM_REGS-1:0] y
);
    always_comb begin
        y = '0;
        for (int i = 0; i < NUM_REGS; i++) y[i] = (a == reg_addr_t'(i));
    end
endmodule

// File: rtl/regfile.sv
// regfile: 32-entry MIPS register file, r0 reads zero, two combinational read ports,
// optional same-cycle write bypass and a never-bypassed debug port
module regfile
    import regfile_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter bit BYPASS = 1'b1
) (
    input logic      clk,
    input logic      rst_n,
    regfile_if.slave bus
);
    logic [NUM_REGS-1:0] sel, en;
    logic [WIDTH-1:0]    r [NUM_REGS];

    decoder5to32 u_dec (.a(bus.wa), .y(sel));
    // en[0] is forced low, so r[0] stays at its reset value and is trimmed as a constant
    assign en = sel & {{(NUM_REGS-1){bus.we}}, 1'b0};

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < NUM_REGS; i++) r[i] <= '0;
        else
            for (int i = 0; i < NUM_REGS; i++) if (en[i]) r[i] <= bus.wd;

    function automatic logic [WIDTH-1:0] rd(input reg_addr_t a);
        return (a == REG_ZERO) ? '0 : r[a];
    endfunction

    generate
        if (BYPASS) begin : g_byp
            logic fwd1, fwd2;
            assign fwd1    = rst_n && bus.we && bus.wa == bus.ra1 && bus.ra1 != REG_ZERO;
            assign fwd2    = rst_n && bus.we && bus.wa == bus.ra2 && bus.ra2 != REG_ZERO;
            assign bus.rd1 = fwd1 ? bus.wd : rd(bus.ra1);
            assign bus.rd2 = fwd2 ? bus.wd : rd(bus.ra2);
        end else begin : g_nobyp
            assign bus.rd1 = rd(bus.ra1);
            assign bus.rd2 = rd(bus.ra2);
        end
    endgenerate

    assign bus.dbg_d = rd(bus.dbg_a);
endmodule
